// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle controller: state encoding, opcodes, datapath select encodings.
package multicycle_control_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    RESET    = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECR    = 4'd7,
    EXECI    = 4'd8,
    ALUWB    = 4'd9,
    JAL      = 4'd10,
    BEQ      = 4'd11,
    ERROR    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_A      = 2'b10;

  localparam logic [1:0] SRCB_WDATA  = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational Moore decode of controller state into datapath controls; only PCWrite looks at zero.
// With MEM_WAIT_EN defined, FETCH strobes and MEMWRITE completion are qualified by mem_ready.
module ctrl_out_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  logic pc_update;
  logic branch;

  always_comb begin
    ctrl      = '0;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
        pc_update       = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMREAD: ctrl.adr_src = 1'b1;
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        pc_update      = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_op     = ALUOP_SUB;
        branch          = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ERROR: ctrl.illegal = 1'b1;
      default: ;
    endcase
    ctrl.pc_write = pc_update | (branch & zero);
`ifdef MEM_WAIT_EN
    // A stalled fetch must not latch the IR or advance the PC.
    if (state == FETCH) begin
      ctrl.ir_write = mem_ready;
      ctrl.pc_write = mem_ready;
    end
    if (state == MEMWRITE) ctrl.instr_done = mem_ready;
`endif
  end

`ifndef MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM; next-state register here, output decode in ctrl_out_decode.
// Optional MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE hold until mem_ready.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUOp,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state;
  state_t state_nxt;
  logic   started;
  ctrl_t  ctrl;

  always_comb begin
    state_nxt = state;
    case (state)
      // RESET is held for one extra edge so the first FETCH lands on the second edge.
      RESET: state_nxt = started ? FETCH : RESET;
`ifdef MEM_WAIT_EN
      FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
      MEMREAD:  state_nxt = mem_ready ? MEMWB  : MEMREAD;
      MEMWRITE: state_nxt = mem_ready ? FETCH  : MEMWRITE;
`else
      FETCH:    state_nxt = DECODE;
      MEMREAD:  state_nxt = MEMWB;
      MEMWRITE: state_nxt = FETCH;
`endif
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_JAL:            state_nxt = JAL;
          OP_BRANCH:         state_nxt = BEQ;
          default:           state_nxt = ERROR;
        endcase
      end
      MEMADR:            state_nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      EXECR, EXECI, JAL: state_nxt = ALUWB;
      MEMWB, ALUWB, BEQ: state_nxt = FETCH;
      ERROR:             state_nxt = ERROR;
      default:           state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
    end
  end

  ctrl_out_decode u_decode (
    .state     (state),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ResultSrc  = ctrl.result_src;
  assign ALUOp      = ctrl.alu_op;
  assign AdrSrc     = ctrl.adr_src;
  assign IRWrite    = ctrl.ir_write;
  assign PCWrite    = ctrl.pc_write;
  assign RegWrite   = ctrl.reg_write;
  assign MemWrite   = ctrl.mem_write;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;
  assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase model feeds an expected-output queue.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal;
  logic [3:0] state_dbg;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] srca, srcb, res, aluop;
    logic       adr, irw, pcw, regw, memw, done, ill;
  } exp_t;

  typedef struct packed {
    state_t s;
    logic   mr;
  } ph_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Output table straight from the per-state control list.
  function automatic exp_t row(input state_t s, input logic z);
    exp_t e;
    e    = '0;
    e.st = s;
    case (s)
      FETCH:    begin e.irw = 1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1; end
      DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      MEMREAD:  e.adr = 1;
      MEMWB:    begin e.res = 2'b01; e.regw = 1; e.done = 1; end
      MEMWRITE: begin e.adr = 1; e.memw = 1; e.done = 1; end
      EXECR:    begin e.srca = 2'b10; e.aluop = 2'b10; end
      EXECI:    begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b10; end
      ALUWB:    begin e.regw = 1; e.done = 1; end
      JAL:      begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      BEQ:      begin e.srca = 2'b10; e.aluop = 2'b01; e.pcw = z; e.done = 1; end
      ERROR:    e.ill = 1;
      default:  ;
    endcase
    return e;
  endfunction

  function automatic ph_t mk(input state_t s, input logic mr);
    ph_t p;
    p.s  = s;
    p.mr = mr;
    return p;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Single compare process: one expected record per cycle, checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e, a;
        e = exp_q.pop_front();
        a = {state_dbg, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
             AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_cmp state=%0d actual=%h required=%h at %0t", e.st, a, e, $time);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
      exp_q.push_back(row(RESET, 1'b0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(row(RESET, 1'b0));
    @(posedge clk); #1;
    exp_q.push_back(row(RESET, 1'b0));
    @(negedge clk); #1;
    check("post_reset_state", state_dbg, RESET);
    check("post_reset_illegal", illegal, 0);
  endtask

  // Builds the phase list of one instruction, drives it, and checks instr_done placement.
  task automatic run_instr(input logic [6:0] o, input logic z, input int fwait, input int mwait,
                           input int exp_len, input int n_err, input int max_cyc);
    ph_t  q[$];
    exp_t e;
    int   n, done_n, done_at;
    done_n  = 0;
    done_at = -1;
    for (int k = 0; k < fwait; k++) q.push_back(mk(FETCH, 1'b0));
    q.push_back(mk(FETCH, 1'b1));
    q.push_back(mk(DECODE, 1'b1));
    case (o)
      7'b0000011: begin
        q.push_back(mk(MEMADR, 1'b1));
        for (int k = 0; k < mwait; k++) q.push_back(mk(MEMREAD, 1'b0));
        q.push_back(mk(MEMREAD, 1'b1));
        q.push_back(mk(MEMWB, 1'b1));
      end
      7'b0100011: begin
        q.push_back(mk(MEMADR, 1'b1));
        for (int k = 0; k < mwait; k++) q.push_back(mk(MEMWRITE, 1'b0));
        q.push_back(mk(MEMWRITE, 1'b1));
      end
      7'b0110011: begin q.push_back(mk(EXECR, 1'b1)); q.push_back(mk(ALUWB, 1'b1)); end
      7'b0010011: begin q.push_back(mk(EXECI, 1'b1)); q.push_back(mk(ALUWB, 1'b1)); end
      7'b1101111: begin q.push_back(mk(JAL, 1'b1));   q.push_back(mk(ALUWB, 1'b1)); end
      7'b1100011: q.push_back(mk(BEQ, 1'b1));
      default: for (int k = 0; k < n_err; k++) q.push_back(mk(ERROR, 1'b1));
    endcase
    n = (max_cyc > 0) ? max_cyc : q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      // op is only meaningful where it is sampled; elsewhere drive a decoy.
      op   = (q[i].s == DECODE || q[i].s == MEMADR) ? o : 7'b1111111;
      zero = z;
      e    = row(q[i].s, z);
`ifdef MEM_WAIT_EN
      mem_ready = q[i].mr;
      if (q[i].s == FETCH) begin e.irw = q[i].mr; e.pcw = q[i].mr; end
      if (q[i].s == MEMWRITE) e.done = q[i].mr;
`else
      mem_ready = i[0];
`endif
      exp_q.push_back(e);
      @(negedge clk); #1;
      if (i == 0 && fwait == 0) check("fetch_strobes", {IRWrite, PCWrite, ALUSrcB}, 4'b1110);
      if (instr_done === 1'b1) begin
        done_n++;
        done_at = i;
      end
    end
    if (exp_len > 0) begin
      check("done_count", done_n, 1);
      check("done_cycle", done_at, exp_len - 1);
    end else begin
      check("no_done", done_n, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(3);
    run_instr(7'b0000011, 1'b0, 0, 0, 5, 0, 0);  // lw
    run_instr(7'b0100011, 1'b0, 0, 0, 4, 0, 0);  // sw
    run_instr(7'b0110011, 1'b0, 0, 0, 4, 0, 0);  // R-type
    run_instr(7'b0010011, 1'b1, 0, 0, 4, 0, 0);  // I-type
    run_instr(7'b1101111, 1'b0, 0, 0, 4, 0, 0);  // jal
    run_instr(7'b1100011, 1'b1, 0, 0, 3, 0, 0);  // beq taken
    run_instr(7'b1100011, 1'b0, 0, 0, 3, 0, 0);  // beq not taken
`ifdef MEM_WAIT_EN
    run_instr(7'b0100011, 1'b0, 2, 3, 9, 0, 0);  // sw, fetch and write stalls
    run_instr(7'b0000011, 1'b0, 1, 2, 8, 0, 0);  // lw, fetch and read stalls
`endif
    // Unsupported opcode: absorbing ERROR, cleared only by reset.
    run_instr(7'b1111111, 1'b0, 0, 0, 0, 10, 0);
    check("illegal_sticky", illegal, 1);
    do_reset(3);
    run_instr(7'b0000011, 1'b0, 0, 0, 5, 0, 0);
    // Abort an R-type in EXECR with an asynchronous reset pulse.
    run_instr(7'b0110011, 1'b0, 0, 0, 0, 0, 3);
    #1 reset = 1'b1;
    #1;
    check("async_reset_state", state_dbg, RESET);
    check("async_reset_regwrite", RegWrite, 0);
    do_reset(3);
    run_instr(7'b0010011, 1'b0, 0, 0, 4, 0, 0);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: STATE_W, default 4, width of the state register and of state_dbg.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  opcode field of the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completion strobe; used only with MEM_WAIT_EN.
REQ-007 ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=A register.
REQ-008 ALUSrcB  out  2  ALU B select: 00=WriteData, 01=ImmExt, 10=constant 4.
REQ-009 ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-010 ALUOp  out  2  ALU operation class: 00=add, 01=sub, 10=funct-decoded.
REQ-011 AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  datapath strobes.
REQ-012 instr_done  out  1  one-cycle pulse in the final state of every instruction.
REQ-013 illegal  out  1  sticky unsupported-opcode flag.
REQ-014 state_dbg  out  STATE_W  current state encoding.

Function
REQ-015 States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, ERROR.
REQ-016 Outputs are decoded from state only (Moore), except PCWrite = PCUpdate | (Branch & zero) and the MEM_WAIT_EN gating.
REQ-017 Outputs not listed for a state are 0.
- RESET: all 0.
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-018 Transitions:
- RESET->FETCH->DECODE.
- DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL; 1100011->BEQ; any other->ERROR.
- MEMADR->MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD->MEMWB; EXECR/EXECI->ALUWB; JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-019 ERROR is absorbing: illegal=1 and all strobes 0 until reset.
REQ-020 instr_done=1 in MEMWB, MEMWRITE, ALUWB and BEQ only.
REQ-021 Cycle counts without wait states: lw 5, sw 4, R/I/jal 4, beq 3.
REQ-022 op is sampled only in DECODE and MEMADR.

Reset
REQ-023 reset asserted: state=RESET immediately (asynchronous), illegal=0, all outputs 0.
REQ-024 reset asserted mid-instruction aborts it with no further strobes; the first FETCH occurs on the second posedge after deassertion.

Configuration
REQ-025 Macro MEM_WAIT_EN. When defined:
- FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
- In FETCH, IRWrite and PCWrite are gated by mem_ready.
- MemWrite stays asserted throughout MEMWRITE.
- instr_done in MEMWRITE only when mem_ready=1.
REQ-026 When MEM_WAIT_EN is undefined, mem_ready is ignored and each of FETCH, MEMREAD and MEMWRITE lasts exactly one cycle.

Structure
REQ-027 Shared package holds:
- state enum;
- opcode constants;
- ALUSrcA, ALUSrcB, ResultSrc and ALUOp encodings.
REQ-028 One sub-module, ctrl_out_decode, maps state (plus zero and mem_ready) to the output vector; the next-state register stays in multicycle_control.

Verification
REQ-029 reset high 3 cycles, then low -> all outputs 0 in RESET; FETCH on 2nd edge with IRWrite=1, PCWrite=1, ALUSrcB=10.
REQ-030 op=0000011 -> sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5; instr_done once.
REQ-031 op=1100011 with zero=1, then zero=0 -> PCWrite=1 in BEQ only for zero=1; ALUOp=01; returns to FETCH after 3 cycles.
REQ-032 op=1111111 -> ERROR after DECODE; illegal stays 1 for 10 cycles; reset clears it.
REQ-033 MEM_WAIT_EN, sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; instr_done only on the mem_ready cycle.
REQ-034 reset pulsed during EXECR -> RegWrite never asserts; state_dbg=RESET asynchronously.
